hazard_controller: RTL

Pipeline control block for the five-stage core: consumes stage state presented by the pipeline registers (ID/EX load destination, EX branch resolution, MEM memory request and halt) and drives back the per-register enable and flush strobes, the PC enable and the `lw_hazard` indication. Holds a small run/wait/halt state machine plus saturating stall and flush counters for performance debug. One instance per core.

---
 rtl/hazard_controller_if.sv | 33 +++
 rtl/hazard_controller.sv | 123 ++++++++++++
 2 files changed

// File: rtl/hazard_controller_if.sv
// Stage-state / control-strobe bundle between the pipeline registers and the hazard controller.
// The pipeline (master) presents stage state; the controller (slave) drives enables and flushes back.
interface hazard_controller_if;
   logic       ihit;
   logic       dhit;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       ex_memread;
   logic [4:0] ex_rd;
   logic       ex_branch_taken;
   logic       mem_dreq;
   logic       mem_halt;

   logic       pc_en;
   logic       ifid_en;
   logic       idex_en;
   logic       exmem_en;
   logic       memwb_en;
   logic       ifid_flush;
   logic       idex_flush;
   logic       lw_hazard;
   logic       halted;

   modport master (
      output ihit, dhit, id_rs, id_rt, ex_memread, ex_rd, ex_branch_taken, mem_dreq, mem_halt,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, lw_hazard, halted
   );

   modport slave (
      input  ihit, dhit, id_rs, id_rt, ex_memread, ex_rd, ex_branch_taken, mem_dreq, mem_halt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, lw_hazard, halted
   );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard controller: run/wait/halt FSM, combinational stall/flush strobes,
// and saturating stall/flush performance counters.
module hazard_controller #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   hazard_controller_if.slave hif,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

   state_t state;
   state_t state_next;

   logic dwait;
   logic luh;
   logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, lw_hazard, halted;
   logic stall_inc;
   logic flush_inc;

   assign dwait = hif.mem_dreq & ~hif.dhit;
   assign luh   = hif.ex_memread & (hif.ex_rd != 5'd0) &
                  ((hif.ex_rd == hif.id_rs) | (hif.ex_rd == hif.id_rt));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Strobes are forced low while reset is held so the pipeline freezes immediately.
   always_comb begin
      state_next = state;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      lw_hazard  = 1'b0;
      halted     = 1'b0;
      flush_inc  = 1'b0;
      if (!RST) begin
         if (state == HALT) begin
            halted = 1'b1;
         end else if (dwait) begin
            state_next = DWAIT;
         end else begin
            state_next = RUN;
            if (hif.mem_halt) begin
               memwb_en   = 1'b1;
               state_next = HALT;
            end else if (hif.ex_branch_taken) begin
               pc_en      = 1'b1;
               ifid_en    = 1'b1;
               idex_en    = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               flush_inc  = 1'b1;
            end else if (luh) begin
               idex_en    = 1'b1;
               idex_flush = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
               lw_hazard  = 1'b1;
            end else if (!hif.ihit) begin
               ifid_en    = 1'b1;
               ifid_flush = 1'b1;
               idex_en    = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
            end else begin
               pc_en      = 1'b1;
               ifid_en    = 1'b1;
               idex_en    = 1'b1;
               exmem_en   = 1'b1;
               memwb_en   = 1'b1;
            end
         end
      end
   end

   assign stall_inc = ~RST & (state != HALT) & ~pc_en;

   assign hif.pc_en      = pc_en;
   assign hif.ifid_en    = ifid_en;
   assign hif.idex_en    = idex_en;
   assign hif.exmem_en   = exmem_en;
   assign hif.memwb_en   = memwb_en;
   assign hif.ifid_flush = ifid_flush;
   assign hif.idex_flush = idex_flush;
   assign hif.lw_hazard  = lw_hazard;
   assign hif.halted     = halted;

   // Counters hold at all-ones; a clear request beats a same-cycle increment.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_inc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (flush_inc && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end

endmodule
